spi_master_fifo: RTL and testbench
==================================

# spi_master_fifo

Parametrised Avalon-MM SPI master for LCD and peripheral control, the successor to the single-word write-only SPI master. It adds configurable word width, TX and RX FIFOs, a programmable SCLK divider, all four CPOL/CPHA modes, MISO capture, and per-word D/C* tagging. It sits between the Nios/Avalon interconnect (avalon_slave, clock_sink, reset_sink) and the SPI conduit to the display or peripheral.

## Interface
- N, 16, SPI word width in bits (1..30)
- DEPTH, 8, entries per FIFO (power of 2, ≥2)
- DIVW, 8, divider field width
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- avs_address  in  2  register select
- avs_write  in  1  write strobe
- avs_read  in  1  read strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, combinational from avs_address (zero-latency)
- coe_sclk  out  1  SPI clock
- coe_mosi  out  1  SPI data out
- coe_miso  in  1  SPI data in
- coe_csn  out  1  chip select, active-low
- coe_dcn  out  1  data/command select
- coe_resetn  out  1  peripheral reset, active-low

## Operation
- Registers:
  - addr 0 TXDATA (write only): push {writedata[N]=dc, writedata[N-1:0]=data}. A push while TX is full is dropped and sets TXOVF.
  - addr 1 CTRL (read/write): bit0 CPOL, bit1 CPHA, bit2 PRST (1 drives coe_resetn=0), bits[8+DIVW-1:8] DIV. Reset value: PRST=1, all other fields 0.
  - addr 2 RXDATA (read pops): returns zero-extended RX head. A read while RX is empty returns 0 and does not pop.
  - addr 3 STATUS: bit0 BUSY, bit1 TXFULL, bit2 TXEMPTY, bit3 RXEMPTY, bit4 RXFULL, bit5 TXOVF, bit6 RXOVR. Writing 1 to bit5 or bit6 clears that flag (W1C).
- FSM states: IDLE, START, SHIFT, HOLD, GAP.
  - IDLE: when TX is not empty, pop TX, latch word and dc, then go to START.
  - START: csn=0, dcn=dc, mosi=MSB. Wait one half-period, then go to SHIFT.
  - SHIFT: toggle sclk every half-period for 2N edges.
    - CPHA=0: sample on odd edges, shift on even edges.
    - CPHA=1: shift on odd edges, sample on even edges.
    - Data is MSB first.
  - HOLD: wait one half-period, then csn=1 and push the received word to RX. If RX is full the word is dropped and RXOVR is set.
  - GAP: wait one half-period, then return to IDLE.
- sclk idles at CPOL. CTRL writes to CPOL/CPHA/DIV take effect at the next START; a write during a transfer does not disturb it.
- BUSY = (state != IDLE) or TX not empty.
- Simultaneous TX push and pop in the same cycle: both occur, including at full, where the push succeeds because the pop frees a slot. The same rule applies to RX.

## Timing
- Half-period = DIV+1 clk cycles. sclk frequency = clk / (2·(DIV+1)).
- A TX push at cycle t with the FSM in IDLE gives: pop at t+1, csn falls at t+2.
- One word occupies csn low for (2N+2)·(DIV+1) cycles, followed by GAP of DIV+1 cycles.
- The RX push occurs on the same clock edge as the csn rising edge.
- Reset values while resetn=0: sclk=0, mosi=0, csn=1, dcn=0, coe_resetn=0. FSM in IDLE, both FIFOs empty, flags cleared.
- Reset asserted mid-transfer aborts immediately with the same values. No partial word is pushed to RX.

## Structure
- Package spi_master_pkg: register address constants, STATUS and CTRL bit indices, FSM state enum.
- Sub-module spi_fifo (synchronous, DEPTH×W, full/empty flags, simultaneous push/pop), instantiated twice: TX with W=N+1, RX with W=N.
- Top level contains the register decode, the FSM, the divider counter and the shift register.

## Test plan
- Reset, then read STATUS -> 0x0C (TXEMPTY, RXEMPTY). Outputs csn=1, coe_resetn=0, sclk=0.
- N=16, DIV=0, mode 0, write TXDATA 0x1A55C with miso looped to mosi -> csn low for 34 cycles, dcn=1, mosi bits 0xA55C MSB first, then RXDATA reads 0xA55C.
- Repeat the transfer in modes 1, 2 and 3 with DIV=3 -> sclk idle level equals CPOL, sample edge matches CPHA, half-period is 4 cycles, RX equals TX.
- Write 9 words without waiting (DEPTH=8) -> 9 frames sent, because the first word pops immediately, no TXOVF. Write 10 with DIV=7 -> TXOVF set, 9 frames sent, W1C 0x20 clears the flag.
- Send 9 words without reading RX -> RXFULL set, RXOVR set, the first 8 words are retained in order.
- Deassert resetn during bit 5 of a frame -> outputs return to reset values immediately, no RX push, a new write after release transfers correctly.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master: register map, CTRL/STATUS bit
// positions and the transfer state machine encoding.
package spi_master_pkg;

    // Avalon register addresses
    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_RXDATA = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_CPOL    = 0;
    localparam int CTRL_CPHA    = 1;
    localparam int CTRL_PRST    = 2;
    localparam int CTRL_DIV_LSB = 8;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_TXFULL  = 1;
    localparam int STAT_TXEMPTY = 2;
    localparam int STAT_RXEMPTY = 3;
    localparam int STAT_RXFULL  = 4;
    localparam int STAT_TXOVF   = 5;
    localparam int STAT_RXOVR   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous DEPTH x W FIFO with a combinational head output. A push while
// full is accepted only when a pop frees a slot in the same cycle; a pop
// while empty is ignored.
module spi_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr_q];

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_master_fifo.sv
// Avalon-MM SPI master with TX/RX FIFOs, programmable SCLK divider, all four
// CPOL/CPHA modes and a per-word D/C* tag carried alongside the TX data.
module spi_master_fifo
    import spi_master_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int DIVW  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        coe_sclk,
    output logic        coe_mosi,
    input  logic        coe_miso,
    output logic        coe_csn,
    output logic        coe_dcn,
    output logic        coe_resetn
);
    localparam int EW = $clog2(2 * N);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * N - 1);

    spi_state_e    state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d, div_l_q, div_l_d, ctrl_div_q, ctrl_div_d;
    logic          cpol_l_q, cpol_l_d, cpha_l_q, cpha_l_d;
    logic          ctrl_cpol_q, ctrl_cpol_d, ctrl_cpha_q, ctrl_cpha_d;
    logic          ctrl_prst_q, ctrl_prst_d;
    logic          txovf_q, txovf_d, rxovr_q, rxovr_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [N-1:0]  tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, tx_shifted;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, csn_q, csn_d, dcn_q, dcn_d;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [N:0]    tx_dout;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [N-1:0]  rx_dout;
    logic          tick;
    logic          unused_bits;

    assign tick       = (cnt_q == div_l_q);
    assign tx_shifted = tx_sr_q << 1;
    assign tx_push    = avs_write && (avs_address == ADDR_TXDATA);
    assign rx_pop     = avs_read  && (avs_address == ADDR_RXDATA);
    assign unused_bits = ^avs_writedata;

    spi_fifo #(.W(N + 1), .DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (avs_writedata[N:0]),
        .dout   (tx_dout),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    spi_fifo #(.W(N), .DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rx_sr_q),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    // CTRL register writes and sticky overflow flags (set wins over W1C)
    always_comb begin
        ctrl_cpol_d = ctrl_cpol_q;
        ctrl_cpha_d = ctrl_cpha_q;
        ctrl_prst_d = ctrl_prst_q;
        ctrl_div_d  = ctrl_div_q;
        txovf_d     = txovf_q;
        rxovr_d     = rxovr_q;
        if (avs_write && avs_address == ADDR_CTRL) begin
            ctrl_cpol_d = avs_writedata[CTRL_CPOL];
            ctrl_cpha_d = avs_writedata[CTRL_CPHA];
            ctrl_prst_d = avs_writedata[CTRL_PRST];
            ctrl_div_d  = avs_writedata[CTRL_DIV_LSB +: DIVW];
        end
        if (avs_write && avs_address == ADDR_STATUS) begin
            if (avs_writedata[STAT_TXOVF]) txovf_d = 1'b0;
            if (avs_writedata[STAT_RXOVR]) rxovr_d = 1'b0;
        end
        if (tx_push && tx_full && !tx_pop) txovf_d = 1'b1;
        if (rx_push && rx_full && !rx_pop) rxovr_d = 1'b1;
    end

    // Zero-latency read mux
    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            ADDR_CTRL: begin
                avs_readdata[CTRL_CPOL] = ctrl_cpol_q;
                avs_readdata[CTRL_CPHA] = ctrl_cpha_q;
                avs_readdata[CTRL_PRST] = ctrl_prst_q;
                avs_readdata[CTRL_DIV_LSB +: DIVW] = ctrl_div_q;
            end
            ADDR_RXDATA: begin
                if (!rx_empty) avs_readdata[N-1:0] = rx_dout;
            end
            ADDR_STATUS: begin
                avs_readdata[STAT_BUSY]    = (state_q != ST_IDLE) || !tx_empty;
                avs_readdata[STAT_TXFULL]  = tx_full;
                avs_readdata[STAT_TXEMPTY] = tx_empty;
                avs_readdata[STAT_RXEMPTY] = rx_empty;
                avs_readdata[STAT_RXFULL]  = rx_full;
                avs_readdata[STAT_TXOVF]   = txovf_q;
                avs_readdata[STAT_RXOVR]   = rxovr_q;
            end
            default: avs_readdata = '0;
        endcase
    end

    // Transfer FSM: next state, divider, shift registers and pin values
    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + DIVW'(1);
        div_l_d    = div_l_q;
        cpol_l_d   = cpol_l_q;
        cpha_l_d   = cpha_l_q;
        edge_cnt_d = edge_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        csn_d      = csn_q;
        dcn_d      = dcn_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                sclk_d = ctrl_cpol_q;
                if (!tx_empty) begin
                    // Mode and divider are frozen here for the whole word
                    tx_pop     = 1'b1;
                    state_d    = ST_START;
                    div_l_d    = ctrl_div_q;
                    cpol_l_d   = ctrl_cpol_q;
                    cpha_l_d   = ctrl_cpha_q;
                    edge_cnt_d = '0;
                    tx_sr_d    = tx_dout[N-1:0];
                    rx_sr_d    = '0;
                    mosi_d     = tx_dout[N-1];
                    dcn_d      = tx_dout[N];
                    csn_d      = 1'b0;
                end
            end
            ST_START: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + EW'(1);
                    // edge_cnt_q[0]==0 marks an odd (1-based) edge
                    if (edge_cnt_q[0] == cpha_l_q) begin
                        rx_sr_d    = rx_sr_q << 1;
                        rx_sr_d[0] = coe_miso;
                    end else if (!(cpha_l_q && edge_cnt_q == '0)) begin
                        // In CPHA=1 the MSB is already on the pin at edge 1
                        tx_sr_d = tx_shifted;
                        mosi_d  = tx_shifted[N-1];
                    end
                    if (edge_cnt_q == LAST_EDGE) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    csn_d   = 1'b1;
                    rx_push = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register bank
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_l_q     <= '0;
            cpol_l_q    <= 1'b0;
            cpha_l_q    <= 1'b0;
            edge_cnt_q  <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            csn_q       <= 1'b1;
            dcn_q       <= 1'b0;
            ctrl_cpol_q <= 1'b0;
            ctrl_cpha_q <= 1'b0;
            ctrl_prst_q <= 1'b1;
            ctrl_div_q  <= '0;
            txovf_q     <= 1'b0;
            rxovr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_l_q     <= div_l_d;
            cpol_l_q    <= cpol_l_d;
            cpha_l_q    <= cpha_l_d;
            edge_cnt_q  <= edge_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            csn_q       <= csn_d;
            dcn_q       <= dcn_d;
            ctrl_cpol_q <= ctrl_cpol_d;
            ctrl_cpha_q <= ctrl_cpha_d;
            ctrl_prst_q <= ctrl_prst_d;
            ctrl_div_q  <= ctrl_div_d;
            txovf_q     <= txovf_d;
            rxovr_q     <= rxovr_d;
        end
    end

    assign coe_sclk   = sclk_q;
    assign coe_mosi   = mosi_q;
    assign coe_csn    = csn_q;
    assign coe_dcn    = dcn_q;
    assign coe_resetn = ~ctrl_prst_q;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: MISO is looped back to MOSI and an
// independent SPI monitor decodes each csn-low frame per the programmed mode.
module tb_spi_master_fifo;
    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int DIVW  = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        coe_sclk, coe_mosi, coe_miso, coe_csn, coe_dcn, coe_resetn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign coe_miso = coe_mosi;

    spi_master_fifo #(.N(N), .DEPTH(DEPTH), .DIVW(DIVW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .coe_sclk      (coe_sclk),
        .coe_mosi      (coe_mosi),
        .coe_miso      (coe_miso),
        .coe_csn       (coe_csn),
        .coe_dcn       (coe_dcn),
        .coe_resetn    (coe_resetn)
    );

    // ---------------- SPI monitor ----------------
    logic         mon_cpha = 1'b0;
    int           frames = 0;
    logic [N-1:0] f_data [64];
    int           f_len  [64];
    int           f_half [64];
    int           f_edges[64];
    logic         f_dcn  [64];
    logic         f_idle [64];

    initial begin
        int cyc, edges, low_cnt, half, last_edge;
        logic csn_p, sclk_p, cur_idle, cur_dcn;
        logic [N-1:0] sh;
        cyc = 0; edges = 0; low_cnt = 0; half = 0; last_edge = 0;
        csn_p = 1'b1; sclk_p = 1'b0; cur_idle = 1'b0; cur_dcn = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (coe_csn == 1'b0) begin
                if (csn_p) begin
                    edges = 0; low_cnt = 0; half = 0; sh = '0;
                    cur_idle = coe_sclk; cur_dcn = coe_dcn;
                end else if (coe_sclk !== sclk_p) begin
                    edges++;
                    if (edges == 2) half = cyc - last_edge;
                    last_edge = cyc;
                    if (((edges % 2) == 1) != mon_cpha) sh = {sh[N-2:0], coe_mosi};
                end
                low_cnt++;
            end else if (!csn_p) begin
                if (frames < 64) begin
                    f_data[frames]  = sh;
                    f_len[frames]   = low_cnt;
                    f_half[frames]  = half;
                    f_edges[frames] = edges;
                    f_dcn[frames]   = cur_dcn;
                    f_idle[frames]  = cur_idle;
                end
                frames++;
            end
            csn_p  = coe_csn;
            sclk_p = coe_sclk;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        #1;
        d = avs_readdata;
        @(negedge clk);
        avs_read    = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frames < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("frames_reached", 32'(frames >= target), 32'd1);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int k;
        k = 0;
        av_read(2'd3, s);
        while (s[0] && k < 5000) begin
            av_read(2'd3, s);
            k++;
        end
        check("idle_reached", {31'd0, s[0]}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [16:0] mode_word [4];
        logic        cpol, cpha;
        int          f0, k;

        mode_word = '{17'h00000, 17'h03C96, 17'h1F00F, 17'h08001};

        // Reset values
        @(negedge clk);
        #1;
        check("rst_csn",    {31'd0, coe_csn},    32'd1);
        check("rst_sclk",   {31'd0, coe_sclk},   32'd0);
        check("rst_mosi",   {31'd0, coe_mosi},   32'd0);
        check("rst_dcn",    {31'd0, coe_dcn},    32'd0);
        check("rst_presetn",{31'd0, coe_resetn}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        av_read(2'd3, rd);
        check("rst_status", rd, 32'h0000_000C);
        av_read(2'd1, rd);
        check("rst_ctrl", rd, 32'h0000_0004);

        // Mode 0, DIV=0, single word with latency check
        av_write(2'd1, 32'h0);
        check("presetn_released", {31'd0, coe_resetn}, 32'd1);
        mon_cpha = 1'b0;
        f0 = frames;
        av_write(2'd0, 32'h0001_A55C);
        check("csn_high_after_push", {31'd0, coe_csn}, 32'd1);
        @(negedge clk);
        check("csn_low_t_plus_2", {31'd0, coe_csn}, 32'd0);
        wait_frames(f0 + 1);
        check("m0_len",   32'(f_len[f0]),   32'd34);
        check("m0_edges", 32'(f_edges[f0]), 32'd32);
        check("m0_dcn",   {31'd0, f_dcn[f0]}, 32'd1);
        check("m0_idle",  {31'd0, f_idle[f0]}, 32'd0);
        check("m0_mosi",  {16'd0, f_data[f0]}, 32'h0000_A55C);
        wait_idle();
        av_read(2'd2, rd);
        check("m0_rx", rd, 32'h0000_A55C);
        av_read(2'd3, rd);
        check("m0_status", rd, 32'h0000_000C);

        // Modes 1..3 with DIV=3 (mode = {CPOL,CPHA})
        for (int m = 1; m < 4; m++) begin
            cpol = (m >= 2);
            cpha = (m % 2 == 1);
            av_write(2'd1, (32'd3 << 8) | {30'd0, cpha, cpol});
            @(negedge clk);
            check($sformatf("m%0d_sclk_idle", m), {31'd0, coe_sclk}, {31'd0, cpol});
            mon_cpha = cpha;
            f0 = frames;
            av_write(2'd0, {15'd0, mode_word[m]});
            wait_frames(f0 + 1);
            check($sformatf("m%0d_len", m),   32'(f_len[f0]),   32'd136);
            check($sformatf("m%0d_half", m),  32'(f_half[f0]),  32'd4);
            check($sformatf("m%0d_edges", m), 32'(f_edges[f0]), 32'd32);
            check($sformatf("m%0d_idle", m),  {31'd0, f_idle[f0]}, {31'd0, cpol});
            check($sformatf("m%0d_dcn", m),   {31'd0, f_dcn[f0]},  {31'd0, mode_word[m][16]});
            check($sformatf("m%0d_mosi", m),  {16'd0, f_data[f0]}, {16'd0, mode_word[m][15:0]});
            wait_idle();
            av_read(2'd2, rd);
            check($sformatf("m%0d_rx", m), rd, {16'd0, mode_word[m][15:0]});
        end

        // 9-word burst at DIV=0: TX exactly fills, RX overflows on word 9
        av_write(2'd1, 32'h0);
        mon_cpha = 1'b0;
        f0 = frames;
        for (int i = 0; i < 9; i++) begin
            av_write(2'd0, {15'd0, i[0], 16'h1111 * 16'(i + 1)});
        end
        av_read(2'd3, rd);
        check("burst9_status_busy", rd, 32'h0000_000B);
        wait_frames(f0 + 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("burst9_mosi%0d", i), {16'd0, f_data[f0 + i]}, {16'd0, 16'h1111 * 16'(i + 1)});
            check($sformatf("burst9_dcn%0d", i),  {31'd0, f_dcn[f0 + i]}, {31'd0, i[0]});
        end
        wait_idle();
        av_read(2'd3, rd);
        check("burst9_status_rxfull", rd, 32'h0000_0054);
        for (int i = 0; i < 8; i++) begin
            av_read(2'd2, rd);
            check($sformatf("burst9_rx%0d", i), rd, {16'd0, 16'h1111 * 16'(i + 1)});
        end
        av_read(2'd2, rd);
        check("rx_empty_read", rd, 32'h0);
        av_write(2'd3, 32'h40);
        av_read(2'd3, rd);
        check("rxovr_cleared", rd, 32'h0000_000C);

        // 10-word burst at DIV=7: word 10 dropped, TXOVF set then cleared
        av_write(2'd1, 32'd7 << 8);
        f0 = frames;
        for (int i = 0; i < 10; i++) begin
            av_write(2'd0, {16'd0, 16'h0101 * 16'(i + 1)});
        end
        av_read(2'd3, rd);
        check("burst10_status_ovf", rd, 32'h0000_002B);
        av_write(2'd3, 32'h20);
        av_read(2'd3, rd);
        check("txovf_cleared", rd, 32'h0000_000B);
        wait_frames(f0 + 9);
        check("burst10_last_mosi", {16'd0, f_data[f0 + 8]}, 32'h0000_0909);
        check("burst10_half", 32'(f_half[f0]), 32'd8);
        repeat (400) @(negedge clk);
        check("burst10_frames", 32'(frames - f0), 32'd9);
        wait_idle();

        // Reset mid-frame during bit 5
        av_write(2'd1, 32'd3 << 8);
        mon_cpha = 1'b0;
        av_write(2'd0, 32'h0001_C3A5);
        k = 0;
        while (coe_csn && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        while (f_edges_live() < 11 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_bit5", {31'd0, coe_csn}, 32'd0);
        resetn = 1'b0;
        #1;
        check("abort_csn",     {31'd0, coe_csn},    32'd1);
        check("abort_sclk",    {31'd0, coe_sclk},   32'd0);
        check("abort_mosi",    {31'd0, coe_mosi},   32'd0);
        check("abort_dcn",     {31'd0, coe_dcn},    32'd0);
        check("abort_presetn", {31'd0, coe_resetn}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        av_read(2'd3, rd);
        check("abort_status", rd, 32'h0000_000C);
        av_read(2'd1, rd);
        check("abort_ctrl", rd, 32'h0000_0004);
        av_write(2'd1, 32'h0);
        f0 = frames;
        av_write(2'd0, 32'h0000_5AA5);
        wait_frames(f0 + 1);
        check("post_rst_len",  32'(f_len[f0]), 32'd34);
        check("post_rst_dcn",  {31'd0, f_dcn[f0]}, 32'd0);
        check("post_rst_mosi", {16'd0, f_data[f0]}, 32'h0000_5AA5);
        wait_idle();
        av_read(2'd2, rd);
        check("post_rst_rx", rd, 32'h0000_5AA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Live SCLK edge count within the current csn-low window
    int live_edges = 0;
    initial begin
        logic sp, cp;
        sp = 1'b0;
        cp = 1'b1;
        forever begin
            @(negedge clk);
            if (coe_csn == 1'b0) begin
                if (cp) live_edges = 0;
                else if (coe_sclk !== sp) live_edges++;
            end
            sp = coe_sclk;
            cp = coe_csn;
        end
    end

    function automatic int f_edges_live();
        return live_edges;
    endfunction

endmodule
